// File: rtl/exchange_order_ingress_if.sv
// Byte-serial order input and strobed order output of the exchange ingress stage.
// The master drives message bytes; the slave presents the issued order.
interface exchange_order_ingress_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_sop;
   logic [4:0]  exchange_client_id;
   logic [15:0] exchange_amount;
   logic        exchange_go;

   modport master (
      output rx_data, rx_valid, rx_sop,
      input  exchange_client_id, exchange_amount, exchange_go
   );

   modport slave (
      input  rx_data, rx_valid, rx_sop,
      output exchange_client_id, exchange_amount, exchange_go
   );
endinterface

// File: rtl/exchange_order_ingress.sv
// Assembles 3-byte exchange orders, filters them, queues them in a FIFO and issues
// each one as a go strobe long enough for the slowclk-domain processor to see once.
module exchange_order_ingress #(
   parameter int DEPTH       = 8,
   parameter int GO_HOLD     = 4,
   parameter int GAP_CYCLES  = 4,
   parameter int NUM_CLIENTS = 32
) (
   input  logic                     clk,
   input  logic                     HRESET,
   exchange_order_ingress_if.slave  bus,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [15:0]              dropped_count,
   output logic [15:0]              overflow_count
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {P_IDLE, P_HDR, P_AMT} parse_state_t;
   typedef enum logic [1:0] {I_IDLE, I_HOLD, I_GAP} issue_state_t;

   parse_state_t  p_state, p_next;
   issue_state_t  i_state, i_next;
   logic [7:0]    hdr_q, amt_hi_q;
   logic          latch_hdr, latch_amt, drop_evt, msg_done;
   logic [15:0]   msg_amount;
   logic          msg_ok, push_req, push_ok, pop, reject_evt, overflow_evt;
   logic          fifo_full, fifo_empty;
   logic [20:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [15:0]   i_cnt, i_cnt_next;

   always_ff @(posedge clk) begin
      if (HRESET) begin
         p_state <= P_IDLE;
         hdr_q    <= '0;
         amt_hi_q <= '0;
      end else begin
         p_state <= p_next;
         if (latch_hdr) hdr_q <= bus.rx_data;
         if (latch_amt) amt_hi_q <= bus.rx_data;
      end
   end

   // A sop arriving mid-message abandons the partial message and starts a new one.
   always_comb begin
      p_next    = p_state;
      latch_hdr = 1'b0;
      latch_amt = 1'b0;
      drop_evt  = 1'b0;
      msg_done  = 1'b0;
      if (bus.rx_valid) begin
         case (p_state)
            P_IDLE: begin
               if (bus.rx_sop) begin
                  latch_hdr = 1'b1;
                  p_next    = P_HDR;
               end
            end
            P_HDR: begin
               if (bus.rx_sop) begin
                  latch_hdr = 1'b1;
                  drop_evt  = 1'b1;
               end else begin
                  latch_amt = 1'b1;
                  p_next    = P_AMT;
               end
            end
            P_AMT: begin
               if (bus.rx_sop) begin
                  latch_hdr = 1'b1;
                  drop_evt  = 1'b1;
                  p_next    = P_HDR;
               end else begin
                  msg_done = 1'b1;
                  p_next   = P_IDLE;
               end
            end
            default: p_next = P_IDLE;
         endcase
      end
   end

   assign msg_amount   = {amt_hi_q, bus.rx_data};
   assign msg_ok       = (hdr_q[7:5] == 3'b001) && (32'(hdr_q[4:0]) < NUM_CLIENTS)
                         && (msg_amount != 16'd0);
   assign push_req     = msg_done && msg_ok;
   assign reject_evt   = msg_done && !msg_ok;
   assign fifo_full    = (fifo_level == (AW+1)'(DEPTH));
   assign fifo_empty   = (fifo_level == '0);
   assign pop          = (i_state == I_IDLE) && !fifo_empty;
   assign push_ok      = push_req && (!fifo_full || pop);
   assign overflow_evt = push_req && fifo_full && !pop;

   // Storage carries no reset; the pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {hdr_q[4:0], msg_amount};
   end

   always_ff @(posedge clk) begin
      if (HRESET) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (HRESET) begin
         dropped_count  <= '0;
         overflow_count <= '0;
      end else begin
         if ((drop_evt || reject_evt) && dropped_count != 16'hFFFF)
            dropped_count <= dropped_count + 16'd1;
         if (overflow_evt && overflow_count != 16'hFFFF)
            overflow_count <= overflow_count + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (HRESET) begin
         i_state                <= I_IDLE;
         i_cnt                  <= '0;
         bus.exchange_client_id <= '0;
         bus.exchange_amount    <= '0;
      end else begin
         i_state <= i_next;
         i_cnt   <= i_cnt_next;
         if (pop) {bus.exchange_client_id, bus.exchange_amount} <= mem[rd_ptr];
      end
   end

   // The gap keeps consecutive strobes distinguishable in the slower domain.
   always_comb begin
      i_next     = i_state;
      i_cnt_next = i_cnt;
      case (i_state)
         I_IDLE: begin
            if (!fifo_empty) begin
               i_next     = I_HOLD;
               i_cnt_next = '0;
            end
         end
         I_HOLD: begin
            if (i_cnt == 16'(GO_HOLD - 1)) begin
               i_next     = I_GAP;
               i_cnt_next = '0;
            end else begin
               i_cnt_next = i_cnt + 16'd1;
            end
         end
         I_GAP: begin
            if (i_cnt == 16'(GAP_CYCLES - 1)) begin
               i_next     = I_IDLE;
               i_cnt_next = '0;
            end else begin
               i_cnt_next = i_cnt + 16'd1;
            end
         end
         default: i_next = I_IDLE;
      endcase
   end

   assign bus.exchange_go = (i_state == I_HOLD);
endmodule
